pll_lock_sequencer: RTL and testbench

- Control end of the PLL interface: generates the PLL `rst` input and consumes its asynchronous `locked` output.
- Runs on the PLL reference clock, which stays stable when the PLL does not.
- Sequences PLL reset pulse, lock wait with timeout, lock-stability qualification and loss-of-lock recovery.
- `ready` gates reset release for the `outclk_0` domain logic.

---
 rtl/pll_lock_sequencer.sv | 75 +++++++
 tb/tb_pll_lock_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset pulse, lock wait with timeout/retries, lock qualification and loss-of-lock recovery
module pll_lock_sequencer #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] retries,
  output logic [7:0] lock_losses
);
  localparam int MAXC = (RESET_CYCLES > LOCK_TIMEOUT) ?
                        ((RESET_CYCLES > LOCK_STABLE) ? RESET_CYCLES : LOCK_STABLE) :
                        ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE);
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {RESET, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic [7:0] ret_nxt, los_nxt;
  logic lk;
  assign lk = sync[SYNC_STAGES-1];
  always_comb begin
    nxt = state;
    ret_nxt = retries;
    los_nxt = lock_losses;
    case (state)
      RESET:     nxt = (cnt == CW'(RESET_CYCLES - 1)) ? WAIT_LOCK : RESET;
      WAIT_LOCK: begin
        if (lk) nxt = STABLE;
        else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          ret_nxt = (retries == 8'hff) ? retries : retries + 8'd1;
          nxt = (ret_nxt > 8'(MAX_RETRIES)) ? FAIL : RESET;
        end
      end
      STABLE:    nxt = !lk ? WAIT_LOCK : (cnt == CW'(LOCK_STABLE - 1)) ? RUN : STABLE;
      RUN: begin
        if (!lk) begin
          nxt = RESET;
          los_nxt = (lock_losses == 8'hff) ? lock_losses : lock_losses + 8'd1;
        end
      end
      FAIL:      nxt = FAIL;
      default:   nxt = RESET;
    endcase
  end
  // Outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= RESET;
      cnt <= '0;
      sync <= '0;
      pll_rst <= 1'b1;
      ready <= 1'b0;
      fail <= 1'b0;
      retries <= 8'd0;
      lock_losses <= 8'd0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : cnt + CW'(1);
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      pll_rst <= (nxt == RESET) || (nxt == FAIL);
      ready <= nxt == RUN;
      fail <= nxt == FAIL;
      retries <= ret_nxt;
      lock_losses <= los_nxt;
    end
  end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios plus random lock patterns against a timestamp-based model
module tb_pll_lock_sequencer;
  localparam int RC = 4, LT = 32, LS = 8, MR = 2, SS = 2;
  localparam int P_PULSE = 0, P_WAIT = 1, P_QUAL = 2, P_RUN = 3, P_DEAD = 4;
  logic refclk = 1'b0, rst = 1'b1, pll_locked = 1'b0;
  logic pll_rst, ready, fail;
  logic [7:0] retries, lock_losses;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int ph, t, m_ret, m_los;
  bit hist[$];
  int k;

  pll_lock_sequencer #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS),
                       .MAX_RETRIES(MR), .SYNC_STAGES(SS)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .ready(ready), .fail(fail), .retries(retries), .lock_losses(lock_losses));

  always #5 refclk = ~refclk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, a, e, $time);
    end
  endtask

  // Phase model: t counts edges spent in the current phase; lk is pll_locked as sampled SS edges ago.
  always @(posedge refclk) begin : model
    bit lk;
    if (rst) begin
      ph = P_PULSE; t = 0; m_ret = 0; m_los = 0;
      hist.delete();
      repeat (SS) hist.push_back(1'b0);
    end else begin
      lk = hist[SS-1];
      t++;
      case (ph)
        P_PULSE: if (t == RC) begin ph = P_WAIT; t = 0; end
        P_WAIT: begin
          if (lk) begin ph = P_QUAL; t = 0; end
          else if (t == LT) begin
            m_ret = (m_ret < 255) ? m_ret + 1 : 255;
            ph = (m_ret > MR) ? P_DEAD : P_PULSE;
            t = 0;
          end
        end
        P_QUAL: begin
          if (!lk) begin ph = P_WAIT; t = 0; end
          else if (t == LS) begin ph = P_RUN; t = 0; end
        end
        P_RUN: if (!lk) begin m_los = (m_los < 255) ? m_los + 1 : 255; ph = P_PULSE; t = 0; end
        default: ;
      endcase
      hist.push_front(pll_locked);
      void'(hist.pop_back());
    end
  end

  always @(negedge refclk) begin
    if (chk_en) begin
      chk("pll_rst", pll_rst, (ph == P_PULSE || ph == P_DEAD) ? 1 : 0);
      chk("ready", ready, (ph == P_RUN) ? 1 : 0);
      chk("fail", fail, (ph == P_DEAD) ? 1 : 0);
      chk("retries", retries, m_ret);
      chk("lock_losses", lock_losses, m_los);
      chk("inv_ready_excl", ready & (pll_rst | fail), 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge refclk);
  endtask

  function automatic logic sig(input int s);
    return (s == 0) ? pll_rst : (s == 1) ? ready : fail;
  endfunction

  task automatic wait_sig(input string n, input int s, input logic v, input int lim, output int cnt);
    cnt = 0;
    do begin
      cyc(1);
      cnt++;
    end while (sig(s) !== v && cnt < lim);
    if (sig(s) !== v) chk({n, "_timeout"}, sig(s), v);
  endtask

  initial begin
    cyc(3);
    chk_en = 1'b1;
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_retries", retries, 0);
    // lock 10 cycles after pll_rst falls
    rst = 1'b0;
    wait_sig("t1_pulse", 0, 1'b0, 100, k);
    chk("t1_pulse_len", k, 4);
    cyc(10);
    pll_locked = 1'b1;
    wait_sig("t1_ready", 1, 1'b1, 100, k);
    chk("t1_latency", k, 11);
    chk("t1_retries", retries, 0);
    chk("t1_losses", lock_losses, 0);
    // loss of lock in RUN
    cyc(3);
    pll_locked = 1'b0;
    wait_sig("t4_drop", 1, 1'b0, 50, k);
    chk("t4_drop_lat", k, 3);
    chk("t4_pll_rst_up", pll_rst, 1);
    chk("t4_losses", lock_losses, 1);
    wait_sig("t4_pulse", 0, 1'b0, 50, k);
    chk("t4_pulse_len", k, 4);
    pll_locked = 1'b1;
    wait_sig("t4_relock", 1, 1'b1, 100, k);
    chk("t4_relock_lat", k, 11);
    // one-cycle rst during RUN
    rst = 1'b1;
    cyc(1);
    chk("t6a_pll_rst", pll_rst, 1);
    chk("t6a_ready", ready, 0);
    chk("t6a_losses", lock_losses, 0);
    rst = 1'b0;
    pll_locked = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    // lock glitch during qualification
    wait_sig("t3_pulse", 0, 1'b0, 100, k);
    pll_locked = 1'b1;
    cyc(8);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    wait_sig("t3_ready", 1, 1'b1, 100, k);
    chk("t3_requal_lat", k, 11);
    chk("t3_retries", retries, 0);
    // lock arrives on the timeout edge
    pll_locked = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    wait_sig("t5_pulse", 0, 1'b0, 100, k);
    cyc(29);
    pll_locked = 1'b1;
    cyc(3);
    chk("t5_retries", retries, 0);
    chk("t5_pll_rst", pll_rst, 0);
    wait_sig("t5_ready", 1, 1'b1, 100, k);
    chk("t5_qual_len", k, 8);
    // no lock at all
    pll_locked = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    wait_sig("t2_fail", 2, 1'b1, 300, k);
    chk("t2_fail_time", k, 108);
    chk("t2_retries", retries, 3);
    chk("t2_pll_rst", pll_rst, 1);
    pll_locked = 1'b1;
    cyc(40);
    chk("t2_sticky", fail, 1);
    chk("t2_ready", ready, 0);
    // one-cycle rst during FAIL
    rst = 1'b1;
    cyc(1);
    chk("t6b_fail", fail, 0);
    chk("t6b_retries", retries, 0);
    chk("t6b_pll_rst", pll_rst, 1);
    rst = 1'b0;
    wait_sig("t6b_ready", 1, 1'b1, 200, k);
    chk("t6b_restart_lat", k, 13);
    // lock_losses saturation
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      cyc(3);
      pll_locked = 1'b1;
      wait_sig("sat_relock", 1, 1'b1, 60, k);
    end
    chk("sat_losses", lock_losses, 255);
    // random lock patterns with occasional reset
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      pll_locked = ($urandom_range(0, 2) != 0);
      cyc($urandom_range(1, 45));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
